// File: rtl/mem_lat_ctrl_np.sv
// mem_lat_ctrl_np: N-port flop-array memory controller with per-port write/read latency pipelines
module mem_lat_ctrl_np #(
  parameter int NUM_PORTS = 2,
  parameter int D_W = 8,
  parameter int A_W = 3,
  parameter int W_LAT [NUM_PORTS] = '{5, 5},
  parameter int R_LAT [NUM_PORTS] = '{6, 6}
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_PORTS-1:0]     en,
  input  logic [NUM_PORTS-1:0]     we,
  input  logic [NUM_PORTS*A_W-1:0] addr,
  input  logic [NUM_PORTS*D_W-1:0] wdata,
  output logic [NUM_PORTS*D_W-1:0] rdata,
  output logic [NUM_PORTS-1:0]     rvalid,
  output logic [NUM_PORTS-1:0]     wack,
  output logic [NUM_PORTS-1:0]     coll
);
  localparam int DEPTH = 2 ** A_W;
  logic [D_W-1:0] mem [DEPTH];
  logic [NUM_PORTS-1:0] cv;
  logic [NUM_PORTS-1:0] lose;
  logic [A_W-1:0] ca [NUM_PORTS];
  logic [D_W-1:0] cd [NUM_PORTS];
  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    if (W_LAT[p] < 1 || R_LAT[p] < 1) begin : g_bad
      $error("mem_lat_ctrl_np: latencies must be >= 1");
    end
    localparam int WL = W_LAT[p];
    localparam int RL = R_LAT[p];
    logic [WL-1:0] wv;
    logic [A_W-1:0] wa [WL];
    logic [D_W-1:0] wd [WL];
    logic [RL-1:0] rv;
    logic [D_W-1:0] rd [RL];
    logic [D_W-1:0] rdata_q;
    logic rvalid_q;
    always_ff @(posedge clk) begin
      if (rst) begin
        wv <= '0;
        rv <= '0;
        rvalid_q <= 1'b0;
        rdata_q <= '0;
      end else begin
        wv[0] <= en[p] && !we[p];
        rv[0] <= en[p] && we[p];
        for (int i = 1; i < WL; i++) wv[i] <= wv[i-1];
        for (int i = 1; i < RL; i++) rv[i] <= rv[i-1];
        rvalid_q <= rv[RL-1];
        rdata_q <= rv[RL-1] ? rd[RL-1] : rdata_q;
      end
    end
    // payload stages need no reset; only the valid bits gate any effect
    always_ff @(posedge clk) begin
      wa[0] <= addr[p*A_W +: A_W];
      wd[0] <= wdata[p*D_W +: D_W];
      rd[0] <= mem[addr[p*A_W +: A_W]];
      for (int i = 1; i < WL; i++) begin
        wa[i] <= wa[i-1];
        wd[i] <= wd[i-1];
      end
      for (int i = 1; i < RL; i++) rd[i] <= rd[i-1];
    end
    assign cv[p] = wv[WL-1];
    assign ca[p] = wa[WL-1];
    assign cd[p] = wd[WL-1];
    assign rvalid[p] = rvalid_q;
    assign rdata[p*D_W +: D_W] = rdata_q;
  end
  // a commit loses if any lower-indexed port commits to the same address on this edge
  always_comb begin
    lose = '0;
    for (int p = 1; p < NUM_PORTS; p++)
      for (int q = 0; q < p; q++)
        if (cv[p] && cv[q] && ca[p] == ca[q]) lose[p] = 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wack <= '0;
      coll <= '0;
    end else begin
      for (int p = NUM_PORTS - 1; p >= 0; p--)
        if (cv[p]) mem[ca[p]] <= cd[p];
      wack <= cv;
      coll <= lose;
    end
  end
endmodule

// File: tb/tb_mem_lat_ctrl_np.sv
// tb_mem_lat_ctrl_np: directed tests of mem_lat_ctrl_np with default and asymmetric latencies
module tb_mem_lat_ctrl_np;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  logic [1:0] en_a, we_a, rvalid_a, wack_a, coll_a;
  logic [5:0] addr_a;
  logic [15:0] wdata_a, rdata_a;
  logic [1:0] en_b, we_b, rvalid_b, wack_b, coll_b;
  logic [5:0] addr_b;
  logic [15:0] wdata_b, rdata_b;
  int total = 0;
  int bad = 0;
  mem_lat_ctrl_np u_a (
    .clk(clk), .rst(rst), .en(en_a), .we(we_a), .addr(addr_a), .wdata(wdata_a),
    .rdata(rdata_a), .rvalid(rvalid_a), .wack(wack_a), .coll(coll_a)
  );
  mem_lat_ctrl_np #(.W_LAT('{1, 3}), .R_LAT('{2, 4})) u_b (
    .clk(clk), .rst(rst), .en(en_b), .we(we_b), .addr(addr_b), .wdata(wdata_b),
    .rdata(rdata_b), .rvalid(rvalid_b), .wack(wack_b), .coll(coll_b)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive_a(input int p, input logic e, input logic w, input logic [2:0] a, input logic [7:0] d);
    en_a[p] = e;
    we_a[p] = w;
    addr_a[p*3 +: 3] = a;
    wdata_a[p*8 +: 8] = d;
  endtask
  task automatic drive_b(input int p, input logic e, input logic w, input logic [2:0] a, input logic [7:0] d);
    en_b[p] = e;
    we_b[p] = w;
    addr_b[p*3 +: 3] = a;
    wdata_b[p*8 +: 8] = d;
  endtask
  task automatic test_reset();
    en_a = '0; we_a = '0; addr_a = '0; wdata_a = '0;
    en_b = '0; we_b = '0; addr_b = '0; wdata_b = '0;
    rst = 1'b1;
    tick();
    tick();
    total++;
    if ({rvalid_a, wack_a, coll_a, rdata_a} !== 22'd0) begin
      bad++;
      $display("FAIL reset_a got rv=%b wack=%b coll=%b rdata=%h exp all 0", rvalid_a, wack_a, coll_a, rdata_a);
    end
    total++;
    if ({rvalid_b, wack_b, coll_b, rdata_b} !== 22'd0) begin
      bad++;
      $display("FAIL reset_b got rv=%b wack=%b coll=%b rdata=%h exp all 0", rvalid_b, wack_b, coll_b, rdata_b);
    end
    rst = 1'b0;
  endtask
  task automatic test_read_latency();
    for (int n = 0; n <= 8; n++) begin
      drive_a(0, n == 0, 1'b1, 3'd3, 8'h00);
      tick();
      total++;
      if (rvalid_a !== (n == 6 ? 2'b01 : 2'b00) || wack_a !== 2'b00 || coll_a !== 2'b00) begin
        bad++;
        $display("FAIL rd_lat n=%0d got rv=%b wack=%b coll=%b exp rv=%b", n, rvalid_a, wack_a, coll_a, (n == 6 ? 2'b01 : 2'b00));
      end
      if (n == 6) begin
        total++;
        if (rdata_a[7:0] !== 8'h00) begin
          bad++;
          $display("FAIL rd_lat_data got=%h exp=00", rdata_a[7:0]);
        end
      end
    end
  endtask
  task automatic test_read_before_write();
    for (int n = 0; n <= 13; n++) begin
      drive_a(0, n == 0, 1'b0, 3'd2, 8'hA5);
      drive_a(1, n == 5 || n == 6, 1'b1, 3'd2, 8'h00);
      tick();
      total++;
      if (wack_a !== (n == 5 ? 2'b01 : 2'b00) || coll_a !== 2'b00) begin
        bad++;
        $display("FAIL rbw_wack n=%0d got wack=%b coll=%b", n, wack_a, coll_a);
      end
      total++;
      if (rvalid_a !== (n == 11 || n == 12 ? 2'b10 : 2'b00)) begin
        bad++;
        $display("FAIL rbw_rvalid n=%0d got=%b", n, rvalid_a);
      end
      if (n == 11 || n == 12) begin
        total++;
        if (rdata_a[15:8] !== (n == 11 ? 8'h00 : 8'hA5)) begin
          bad++;
          $display("FAIL rbw_data n=%0d got=%h exp=%h", n, rdata_a[15:8], (n == 11 ? 8'h00 : 8'hA5));
        end
      end
    end
  endtask
  task automatic test_collision();
    for (int n = 0; n <= 13; n++) begin
      drive_a(0, n == 0 || n == 6, n == 6, 3'd7, 8'h11);
      drive_a(1, n == 0, 1'b0, 3'd7, 8'h22);
      tick();
      total++;
      if (wack_a !== (n == 5 ? 2'b11 : 2'b00) || coll_a !== (n == 5 ? 2'b10 : 2'b00)) begin
        bad++;
        $display("FAIL coll_ack n=%0d got wack=%b coll=%b", n, wack_a, coll_a);
      end
      total++;
      if (rvalid_a !== (n == 12 ? 2'b01 : 2'b00)) begin
        bad++;
        $display("FAIL coll_rvalid n=%0d got=%b", n, rvalid_a);
      end
      if (n == 12) begin
        total++;
        if (rdata_a[7:0] !== 8'h11) begin
          bad++;
          $display("FAIL coll_data got=%h exp=11", rdata_a[7:0]);
        end
      end
    end
  endtask
  task automatic test_back_to_back();
    drive_a(1, 1'b0, 1'b0, 3'd0, 8'h00);
    for (int n = 0; n <= 27; n++) begin
      drive_a(0, n < 8 || (n >= 13 && n < 21), n >= 13, (n < 8 ? 3'(n) : 3'(n - 13)), 8'(8'h10 + n));
      tick();
      total++;
      if (wack_a !== (n >= 5 && n <= 12 ? 2'b01 : 2'b00)) begin
        bad++;
        $display("FAIL b2b_wack n=%0d got=%b", n, wack_a);
      end
      total++;
      if (rvalid_a !== (n >= 19 && n <= 26 ? 2'b01 : 2'b00)) begin
        bad++;
        $display("FAIL b2b_rvalid n=%0d got=%b", n, rvalid_a);
      end
      if (n >= 19 && n <= 26) begin
        total++;
        if (rdata_a[7:0] !== 8'(8'h10 + n - 19)) begin
          bad++;
          $display("FAIL b2b_data n=%0d got=%h exp=%h", n, rdata_a[7:0], 8'(8'h10 + n - 19));
        end
      end
    end
  endtask
  task automatic test_reset_inflight();
    for (int n = 0; n <= 18; n++) begin
      rst = (n == 2);
      drive_a(0, n == 0 || n == 10 || n == 11, n != 0, (n == 11 ? 3'd5 : 3'd1), 8'h5A);
      tick();
      total++;
      if (wack_a !== 2'b00 || coll_a !== 2'b00) begin
        bad++;
        $display("FAIL rstf_wack n=%0d got wack=%b coll=%b exp 00", n, wack_a, coll_a);
      end
      total++;
      if (rvalid_a !== (n == 16 || n == 17 ? 2'b01 : 2'b00)) begin
        bad++;
        $display("FAIL rstf_rvalid n=%0d got=%b", n, rvalid_a);
      end
      if (n == 2 || n == 16 || n == 17) begin
        total++;
        if (rdata_a[7:0] !== 8'h00) begin
          bad++;
          $display("FAIL rstf_data n=%0d got=%h exp=00", n, rdata_a[7:0]);
        end
      end
    end
    rst = 1'b0;
  endtask
  task automatic test_asym_latency();
    for (int n = 0; n <= 12; n++) begin
      drive_b(0, n == 0 || n == 5, n == 5, 3'd4, 8'h44);
      drive_b(1, n == 0 || n == 5, n == 5, 3'd5, 8'h55);
      tick();
      total++;
      if (wack_b !== (n == 1 ? 2'b01 : n == 3 ? 2'b10 : 2'b00) || coll_b !== 2'b00) begin
        bad++;
        $display("FAIL asym_wack n=%0d got wack=%b coll=%b", n, wack_b, coll_b);
      end
      total++;
      if (rvalid_b !== (n == 7 ? 2'b01 : n == 9 ? 2'b10 : 2'b00)) begin
        bad++;
        $display("FAIL asym_rvalid n=%0d got=%b", n, rvalid_b);
      end
      if (n == 7) begin
        total++;
        if (rdata_b[7:0] !== 8'h44) begin
          bad++;
          $display("FAIL asym_data0 got=%h exp=44", rdata_b[7:0]);
        end
      end
      if (n == 9) begin
        total++;
        if (rdata_b[15:8] !== 8'h55) begin
          bad++;
          $display("FAIL asym_data1 got=%h exp=55", rdata_b[15:8]);
        end
      end
    end
  endtask
  initial begin
    test_reset();
    test_read_latency();
    test_read_before_write();
    test_collision();
    test_back_to_back();
    test_reset_inflight();
    test_asym_latency();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
